// File: rtl/key_debounce_event.sv
// Push-key conditioner: two-flop synchroniser, per-key debounce counter,
// press/release pulses and a lowest-index-first press event queue with valid/ack.
module key_debounce_event #(
    parameter int unsigned KEY_W      = 4,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic             key_valid,
    output logic [2:0]       key_code,
    input  logic             key_ack,
    output logic             key_ovf
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [KEY_W-1:0] r_s1;
    logic [KEY_W-1:0] r_s2;
    logic [KEY_W-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt [KEY_W];
    logic [KEY_W-1:0] r_press;
    logic [KEY_W-1:0] r_release;
    logic [KEY_W-1:0] r_pending;
    logic             r_valid;
    logic [2:0]       r_code;
    logic             r_ovf;

    logic [KEY_W-1:0] w_flip;
    logic [KEY_W-1:0] w_held;
    logic [KEY_W-1:0] w_hit;
    logic [KEY_W-1:0] w_avail;
    logic [KEY_W-1:0] w_pick;
    logic [2:0]       w_pick_idx;
    logic             w_load;

    // Debounce acceptance and event-queue next-state decode
    always_comb begin
        w_flip     = '0;
        w_held     = '0;
        w_pick_idx = 3'd0;
        for (int i = 0; i < int'(KEY_W); i++) begin
            w_flip[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
            w_held[i] = r_valid && (r_code == 3'(i));
        end
        // A press on a key already pending or already presented is lost
        w_hit   = r_press & (r_pending | w_held);
        w_avail = r_pending | (r_press & ~w_hit);
        w_pick  = w_avail & (~w_avail + KEY_W'(1));
        for (int i = int'(KEY_W) - 1; i >= 0; i--) begin
            if (w_avail[i]) begin
                w_pick_idx = 3'(i);
            end
        end
        w_load = (!r_valid || key_ack) && (w_avail != '0);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_s1      <= '1;
            r_s2      <= '1;
            r_stable  <= '1;
            r_press   <= '0;
            r_release <= '0;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_code    <= 3'd0;
            r_ovf     <= 1'b0;
            for (int i = 0; i < int'(KEY_W); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= key;
            r_s2 <= r_s1;
            for (int i = 0; i < int'(KEY_W); i++) begin
                if ((r_s2[i] == r_stable[i]) || w_flip[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            r_stable  <= r_stable ^ w_flip;
            r_press   <= w_flip & r_stable;
            r_release <= w_flip & ~r_stable;
            if (w_hit != '0) begin
                r_ovf <= 1'b1;
            end
            // Reload back-to-back on ack so no idle cycle appears between events
            if (w_load) begin
                r_valid   <= 1'b1;
                r_code    <= w_pick_idx;
                r_pending <= w_avail & ~w_pick;
            end else begin
                r_pending <= w_avail;
                if (r_valid && key_ack) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign key_state   = ~r_stable;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_valid   = r_valid;
    assign key_code    = r_code;
    assign key_ovf     = r_ovf;

endmodule
